magnetron_control: RTL and testbench

//  Cooking-cycle controller directly downstream of the timer: consumes timer_done and drives the

---
 rtl/magnetron_control.sv | 161 ++++++++++++++++
 tb/tb_magnetron_control.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/magnetron_control.sv
// -----------------------------------------------------------------------------
// magnetron_control
//
// Cooking-cycle controller for a microwave oven. It sits directly downstream of
// the countdown timer. It takes keypad digits, start/stop presses and the door
// switch. It drives the timer's enable/loadn/clearn inputs and the magnetron.
// It also sounds the completion alarm for ALARM_CYCLES clock cycles.
//
// Ports
//   CLK           in   system clock (1 Hz); all state changes on posedge
//   clearn        in   asynchronous active-low reset
//   startn        in   start button, active-low level, synchronous to CLK
//   stopn         in   stop/cancel button, active-low level, synchronous to CLK
//   door_closed   in   1 = door closed
//   key_valid     in   1 = keypad presents a digit this cycle
//   timer_done    in   1 = timer reads 0:00
//   timer_enable  out  timer count enable (combinational)
//   timer_loadn   out  0 = timer shifts a digit in on this posedge (combinational)
//   timer_clearn  out  0 = clear timer (registered one-cycle pulse)
//   mag_on        out  magnetron drive (combinational)
//   alarm         out  completion buzzer (registered)
//   state         out  current state encoding, for debug/display
// -----------------------------------------------------------------------------
module magnetron_control #(
  parameter int ALARM_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       clearn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic       timer_done,
  output logic       timer_enable,
  output logic       timer_loadn,
  output logic       timer_clearn,
  output logic       mag_on,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Value of the DONE-cycle counter on the last alarm cycle.
  localparam logic [3:0] ALARM_LAST = 4'(ALARM_CYCLES - 1);

  state_e     state_q, state_d, state_eff;
  logic       startn_q, stopn_q;
  logic       start_p, stop_p;
  logic       clear_d;
  logic       timer_clearn_q;
  logic       alarm_q, alarm_d;
  logic [3:0] alarm_cnt_q, alarm_cnt_d;
  logic       cooking;

  // One pulse per falling edge of each button; holding a button gives one press.
  assign start_p = startn_q & ~startn;
  assign stop_p  = stopn_q & ~stopn;

  // Encodings 5..7 cannot be reached, but if they are ever seen they behave as IDLE.
  always_comb begin
    state_eff = IDLE;
    if (state_q inside {IDLE, SETUP, COOK, PAUSE, DONE}) begin
      state_eff = state_q;
    end
  end

  // Next-state logic. When a start press and a stop press arrive together, the stop
  // press wins because every branch tests stop_p before start_p.
  always_comb begin
    state_d     = state_eff;
    clear_d     = 1'b0;
    alarm_cnt_d = 4'd0;
    case (state_eff)
      IDLE: begin
        if (stop_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (key_valid) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (stop_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (key_valid) begin
          state_d = SETUP;
        end else if (start_p && door_closed && !timer_done) begin
          state_d = COOK;
        end
      end
      COOK: begin
        if (timer_done) begin
          state_d = DONE;
        end else if (!door_closed || stop_p) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (stop_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (start_p && door_closed) begin
          state_d = COOK;   // resume: the timer keeps its remaining count
        end
      end
      DONE: begin
        alarm_cnt_d = alarm_cnt_q + 4'd1;
        if (stop_p) begin
          state_d = IDLE;
        end else if (key_valid) begin
          state_d = SETUP;
        end else if (alarm_cnt_q >= ALARM_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The alarm is asserted for exactly the cycles spent in DONE. The counter is
    // zero on every DONE entry, because alarm_cnt_d defaults to 0 outside DONE.
    alarm_d = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge clearn) begin
    if (!clearn) begin
      state_q        <= IDLE;
      startn_q       <= 1'b1;
      stopn_q        <= 1'b1;
      timer_clearn_q <= 1'b0;
      alarm_q        <= 1'b0;
      alarm_cnt_q    <= 4'd0;
    end else begin
      state_q        <= state_d;
      startn_q       <= startn;
      stopn_q        <= stopn;
      timer_clearn_q <= ~clear_d;
      alarm_q        <= alarm_d;
      alarm_cnt_q    <= alarm_cnt_d;
    end
  end

  // These outputs are combinational. They stop the timer before it can count past 0:00.
  // They also drop the magnetron as soon as the door opens, a cycle before PAUSE.
  assign cooking      = (state_eff == COOK) & door_closed & ~timer_done;
  assign mag_on       = cooking;
  assign timer_enable = cooking;
  assign timer_loadn  = ~(key_valid & (state_eff inside {IDLE, SETUP, DONE}));
  assign timer_clearn = timer_clearn_q;
  assign alarm        = alarm_q;
  assign state        = state_q;

endmodule

// File: tb/tb_magnetron_control.sv
// -----------------------------------------------------------------------------
// tb_magnetron_control
//
// Scoreboard bench for magnetron_control. The stimulus process drives inputs
// shortly after each rising edge. It asks a behavioural oven model for the
// outputs expected in that cycle and queues them. A separate monitor pops and
// compares on every falling edge. Directed scenarios come first, then a
// randomized run with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_magnetron_control;

  localparam int ALARM = 3;

  localparam int M_IDLE  = 0;
  localparam int M_SETUP = 1;
  localparam int M_COOK  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic       CLK = 1'b0;
  logic       clearn, startn, stopn, door_closed, key_valid, timer_done;
  logic       timer_enable, timer_loadn, timer_clearn, mag_on, alarm;
  logic [2:0] state;

  magnetron_control #(.ALARM_CYCLES(ALARM)) dut (
    .CLK          (CLK),
    .clearn       (clearn),
    .startn       (startn),
    .stopn        (stopn),
    .door_closed  (door_closed),
    .key_valid    (key_valid),
    .timer_done   (timer_done),
    .timer_enable (timer_enable),
    .timer_loadn  (timer_loadn),
    .timer_clearn (timer_clearn),
    .mag_on       (mag_on),
    .alarm        (alarm),
    .state        (state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] st;
    logic       alarm;
    logic       clearn;
    logic       mag;
    logic       en;
    logic       loadn;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // ---------------------------------------------------------------- oven model
  int m_state;
  int m_alarm_left;   // alarm cycles still to sound while in DONE
  bit m_prev_start, m_prev_stop;
  bit m_clearn;       // expected registered timer_clearn

  task automatic model_reset();
    m_state      = M_IDLE;
    m_alarm_left = 0;
    m_prev_start = 1'b1;
    m_prev_stop  = 1'b1;
    m_clearn     = 1'b0;
  endtask

  // Apply the rules for the inputs present at this rising edge.
  task automatic model_tick();
    bit start_press, stop_press, clr;
    int nxt;
    start_press = m_prev_start && !startn;
    stop_press  = m_prev_stop && !stopn;
    nxt = m_state;
    clr = 1'b0;
    if (m_state == M_IDLE) begin
      if (stop_press) clr = 1'b1;
      else if (key_valid) nxt = M_SETUP;
    end else if (m_state == M_SETUP) begin
      if (stop_press) begin nxt = M_IDLE; clr = 1'b1; end
      else if (!key_valid && start_press && door_closed && !timer_done) nxt = M_COOK;
    end else if (m_state == M_COOK) begin
      if (timer_done) nxt = M_DONE;
      else if (!door_closed) nxt = M_PAUSE;
      else if (stop_press) nxt = M_PAUSE;
    end else if (m_state == M_PAUSE) begin
      if (stop_press) begin nxt = M_IDLE; clr = 1'b1; end
      else if (start_press && door_closed) nxt = M_COOK;
    end else begin
      if (stop_press) nxt = M_IDLE;
      else if (key_valid) nxt = M_SETUP;
      else if (m_alarm_left <= 1) nxt = M_IDLE;
      else m_alarm_left--;
    end
    if (nxt == M_DONE && m_state != M_DONE) m_alarm_left = ALARM;
    m_state      = nxt;
    m_clearn     = !clr;
    m_prev_start = startn;
    m_prev_stop  = stopn;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    bit   cook_on;
    cook_on  = (m_state == M_COOK) && door_closed && !timer_done;
    e.st     = 3'(m_state);
    e.alarm  = (m_state == M_DONE);
    e.clearn = m_clearn;
    e.mag    = cook_on;
    e.en     = cook_on;
    e.loadn  = !(key_valid && (m_state == M_IDLE || m_state == M_SETUP || m_state == M_DONE));
    return e;
  endfunction

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state",        state,                 e.st);
        check("alarm",        {2'b0, alarm},         {2'b0, e.alarm});
        check("timer_clearn", {2'b0, timer_clearn},  {2'b0, e.clearn});
        check("mag_on",       {2'b0, mag_on},        {2'b0, e.mag});
        check("timer_enable", {2'b0, timer_enable},  {2'b0, e.en});
        check("timer_loadn",  {2'b0, timer_loadn},   {2'b0, e.loadn});
        $display("cyc st=%0d alarm=%b clrn=%b mag=%b en=%b loadn=%b", state, alarm,
                 timer_clearn, mag_on, timer_enable, timer_loadn);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Queue this cycle's expectation, then move the model across the next edge.
  task automatic push_and_tick();
    q.push_back(model_outputs());
    @(posedge CLK);
    if (clearn) model_tick();
    #1;
  endtask

  task automatic step(input bit s, input bit p, input bit d, input bit k, input bit t);
    startn = s; stopn = p; door_closed = d; key_valid = k; timer_done = t;
    push_and_tick();
  endtask

  // Asynchronous reset in the middle of a cycle; the outputs must fall immediately.
  task automatic mid_cycle_reset(input bit check_now);
    startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; key_valid = 1'b0; timer_done = 1'b0;
    #2;
    clearn = 1'b0;
    #1;
    if (check_now) begin
      check("async_mag_on",       {2'b0, mag_on},       3'd0);
      check("async_timer_enable", {2'b0, timer_enable}, 3'd0);
      check("async_state",        state,                3'd0);
      check("async_timer_clearn", {2'b0, timer_clearn}, 3'd0);
    end
    model_reset();
    push_and_tick();
    clearn = 1'b1;
  endtask

  initial begin : stim
    clearn = 1'b0; startn = 1'b1; stopn = 1'b1;
    door_closed = 1'b1; key_valid = 1'b0; timer_done = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    push_and_tick();            // reset state observed while clearn is low
    clearn = 1'b1;

    // Three digits, then a start press with the door closed: SETUP -> COOK.
    step(1,1,1,0,0);
    repeat (3) step(1,1,1,1,0);
    step(0,1,1,0,0);
    step(0,1,1,0,0);
    step(1,1,1,0,0);
    // Timer reaches 0:00: the enable drops at once, then DONE with the alarm, then IDLE.
    repeat (4) step(1,1,1,0,1);
    repeat (2) step(1,1,1,0,0);
    // Cook again, open the door, close it and resume.
    step(1,1,1,1,0);
    step(0,1,1,0,0);
    step(1,1,0,0,0);
    step(1,1,0,0,0);
    step(0,1,1,0,0);
    step(1,1,1,0,0);
    // Start and stop together in COOK: stop wins. A held stop is not a second press.
    step(0,0,1,0,0);
    step(0,0,1,0,0);
    step(1,1,1,0,0);
    step(1,0,1,0,0);            // stop in PAUSE -> IDLE with one clear pulse
    repeat (2) step(1,1,1,0,0);
    // SETUP with the timer at 0:00, and then with the door open: start is ignored.
    step(1,1,1,1,1);
    step(0,1,1,0,1);
    step(1,1,0,0,0);
    step(0,1,0,0,0);
    step(1,1,1,0,0);
    // Cook, present a digit in COOK, then reset between edges.
    step(0,1,1,0,0);
    step(1,1,1,1,0);
    step(1,1,1,0,0);
    mid_cycle_reset(1'b1);
    step(1,1,1,0,0);
    // Stop from DONE, and a key from DONE.
    step(1,1,1,1,0);
    step(0,1,1,0,0);
    step(1,1,1,0,1);
    step(1,0,1,0,0);
    step(1,1,1,0,0);
    step(1,1,1,1,0);
    step(0,1,1,0,0);
    step(1,1,1,0,1);
    step(1,1,1,1,0);
    step(1,1,1,0,0);

    // Randomized run.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_cycle_reset(1'b0);
      end else begin
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 15) != 0,
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0);
      end
    end

    @(negedge CLK);
    #1;
    check("queue_drained", 3'(q.size()), 3'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
